// File: rtl/jpeg_top_four.sv
// JPEG front end: RGB capture, YCbCr level shift and 8x8 separable DCT
// on three channels, streaming 64 coefficients per channel.
module jpeg_top_four (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         R,
  input  logic [7:0]         G,
  input  logic [7:0]         B,
  input  logic               pixel_valid,
  output logic signed [15:0] dct_Y,
  output logic signed [15:0] dct_Cb,
  output logic signed [15:0] dct_Cr,
  output logic               dct_valid,
  output logic [5:0]         dct_index,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ROW, COL, OUT, FIN
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        adv;

  logic signed [8:0]  fbuf [3][64];
  logic signed [15:0] tmp  [3][64];
  logic signed [15:0] fout [3][64];
  logic signed [31:0] acc  [3];
  logic signed [31:0] sum  [3];
  logic signed [15:0] rnd  [3];
  logic signed [15:0] dat  [3];
  logic signed [15:0] hold [3];
  logic [5:0]         idx_q;
  logic signed [7:0]  coef;

  logic signed [17:0] rs, gs, bs;
  logic signed [17:0] ysum, cbsum, crsum;
  logic signed [8:0]  cin [3];

  // T[k][n]: cosine index folded into the first quadrant
  function automatic logic signed [7:0] tcoef(
    input logic [2:0] k,
    input logic [2:0] n
  );
    logic [4:0] m;
    logic       neg;
    logic [6:0] mag;
    m   = 5'({1'b0, n, 1'b1} * {2'b00, k});
    neg = 1'b0;
    if (m > 5'd16) m = 5'd0 - m;
    if (m > 5'd8) begin
      m   = 5'd16 - m;
      neg = 1'b1;
    end
    case (m)
      5'd1:    mag = 7'd126;
      5'd2:    mag = 7'd118;
      5'd3:    mag = 7'd106;
      5'd4:    mag = 7'd91;
      5'd5:    mag = 7'd71;
      5'd6:    mag = 7'd49;
      5'd7:    mag = 7'd25;
      default: mag = 7'd0;
    endcase
    if (k == 3'd0) return 8'sd91;
    return neg ? -$signed({1'b0, mag})
               :  $signed({1'b0, mag});
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (pixel_valid && cnt_q[5:0] == 6'd63)
              state_d = ROW;
      ROW:  if (cnt_q == 9'd511) state_d = COL;
      COL:  if (cnt_q == 9'd511) state_d = OUT;
      OUT:  if (cnt_q[5:0] == 6'd63) state_d = FIN;
      FIN:  if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adv = (state_q inside {ROW, COL, OUT})
       || (state_q == LOAD && pixel_valid);
    if (state_d != state_q) cnt_d = '0;
    else if (adv)           cnt_d = cnt_q + 9'd1;
    else                    cnt_d = cnt_q;
  end

  always_comb begin
    rs = $signed({10'd0, R});
    gs = $signed({10'd0, G});
    bs = $signed({10'd0, B});
    ysum  = 18'sd77 * rs + 18'sd150 * gs + 18'sd29 * bs;
    cbsum = 18'sd128 * bs - 18'sd43 * rs - 18'sd85 * gs;
    crsum = 18'sd128 * rs - 18'sd107 * gs - 18'sd21 * bs;
    cin[0] = 9'((ysum >>> 8) - 18'sd128);
    cin[1] = 9'(cbsum >>> 8);
    cin[2] = 9'(crsum >>> 8);
  end

  // ROW walks f[y][x] with T[u][x]; COL walks tmp[y][u] with T[v][y]
  always_comb begin
    coef = (state_q == ROW) ? tcoef(cnt_q[5:3], cnt_q[2:0])
                            : tcoef(cnt_q[8:6], cnt_q[2:0]);
    for (int c = 0; c < 3; c++) begin
      dat[c] = (state_q == ROW)
             ? 16'(fbuf[c][{cnt_q[8:6], cnt_q[2:0]}])
             : tmp[c][{cnt_q[2:0], cnt_q[5:3]}];
      sum[c] = ((cnt_q[2:0] == 3'd0) ? 32'sd0 : acc[c])
             + 32'(dat[c]) * 32'(coef);
      rnd[c] = 16'((sum[c] + 32'sd128) >>> 8);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (state_q == LOAD && pixel_valid)
        fbuf[c][cnt_q[5:0]] <= cin[c];
      if (state_q inside {ROW, COL})
        acc[c] <= sum[c];
      if (state_q == ROW && cnt_q[2:0] == 3'd7)
        tmp[c][cnt_q[8:3]] <= rnd[c];
      if (state_q == COL && cnt_q[2:0] == 3'd7)
        fout[c][cnt_q[8:3]] <= rnd[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) hold[c] <= '0;
      idx_q <= '0;
    end else if (state_q == OUT) begin
      for (int c = 0; c < 3; c++)
        hold[c] <= fout[c][cnt_q[5:0]];
      idx_q <= cnt_q[5:0];
    end
  end

  always_comb begin
    dct_valid = (state_q == OUT);
    done      = (state_q == FIN);
    dct_index = dct_valid ? cnt_q[5:0] : idx_q;
    dct_Y     = dct_valid ? fout[0][cnt_q[5:0]] : hold[0];
    dct_Cb    = dct_valid ? fout[1][cnt_q[5:0]] : hold[1];
    dct_Cr    = dct_valid ? fout[2][cnt_q[5:0]] : hold[2];
  end

endmodule

// File: tb/tb_jpeg_top_four.sv
// Self-checking bench for jpeg_top_four against a matrix-form
// reference of the colour conversion and two-pass DCT.
module tb_jpeg_top_four;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              pixel_valid = 1'b0;
  logic [7:0]        R = '0, G = '0, B = '0;
  logic signed [15:0] dct_Y, dct_Cb, dct_Cr;
  logic              dct_valid;
  logic [5:0]        dct_index;
  logic              done;

  int checks = 0;
  int failures = 0;
  int tab [8][8];
  int pr [64], pg [64], pb [64];
  int ef [3][64];
  int obs [3][64];

  jpeg_top_four dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .R(R), .G(G), .B(B), .pixel_valid(pixel_valid),
    .dct_Y(dct_Y), .dct_Cb(dct_Cb), .dct_Cr(dct_Cr),
    .dct_valid(dct_valid), .dct_index(dct_index),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic build_table();
    real pi, a, v;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
        v = 256.0 * a * $cos(real'((2 * n + 1) * k) * pi / 16.0);
        tab[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      end
  endtask

  task automatic model();
    int f [3][64];
    int t [3][64];
    for (int k = 0; k < 64; k++) begin
      f[0][k] = ((77 * pr[k] + 150 * pg[k] + 29 * pb[k]) >>> 8) - 128;
      f[1][k] = (-43 * pr[k] - 85 * pg[k] + 128 * pb[k]) >>> 8;
      f[2][k] = (128 * pr[k] - 107 * pg[k] - 21 * pb[k]) >>> 8;
    end
    for (int c = 0; c < 3; c++)
      for (int y = 0; y < 8; y++)
        for (int u = 0; u < 8; u++) begin
          int s;
          s = 0;
          for (int x = 0; x < 8; x++) s += f[c][8 * y + x] * tab[u][x];
          t[c][8 * y + u] = (s + 128) >>> 8;
        end
    for (int c = 0; c < 3; c++)
      for (int v = 0; v < 8; v++)
        for (int u = 0; u < 8; u++) begin
          int s;
          s = 0;
          for (int y = 0; y < 8; y++) s += tab[v][y] * t[c][8 * y + u];
          ef[c][8 * v + u] = (s + 128) >>> 8;
        end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 64; i++) begin
      pr[i] = i; pg[i] = i + 1; pb[i] = i + 2;
    end
  endtask

  task automatic set_flat(input int v);
    for (int i = 0; i < 64; i++) begin
      pr[i] = v; pg[i] = v; pb[i] = v;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 64; i++) begin
      pr[i] = int'($urandom_range(255));
      pg[i] = int'($urandom_range(255));
      pb[i] = int'($urandom_range(255));
    end
  endtask

  task automatic feed(input bit gap);
    for (int k = 0; k < 64; k++) begin
      if (gap) begin
        pixel_valid = 1'b0;
        R = 8'($urandom);
        @(negedge clk);
      end
      R = 8'(pr[k]); G = 8'(pg[k]); B = 8'(pb[k]);
      pixel_valid = 1'b1;
      @(negedge clk);
    end
    pixel_valid = 1'b0;
  endtask

  task automatic run_block(input string nm, input bit gap,
                           input bit start_mid);
    int n, nv;
    model();
    @(negedge clk);
    start = 1'b1; pixel_valid = 1'b1;
    R = 8'hAA; G = 8'h11; B = 8'h55;
    @(negedge clk);
    start = 1'b0; pixel_valid = 1'b0;
    chk({nm, "_done_low_after_start"}, int'(done), 0);
    feed(gap);
    n = 0; nv = 0;
    while (!done && n < 1300) begin
      start = start_mid && (n == 200);
      @(negedge clk);
      n++;
      if (dct_valid) begin
        chk($sformatf("%s_index%0d", nm, nv), int'(dct_index), nv);
        if (nv < 64) begin
          obs[0][nv] = int'(dct_Y);
          obs[1][nv] = int'(dct_Cb);
          obs[2][nv] = int'(dct_Cr);
        end
        nv++;
      end
    end
    start = 1'b0;
    chk({nm, "_done_latency"}, n, 1088);
    chk({nm, "_valid_count"}, nv, 64);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("%s_Y%0d", nm, i), obs[0][i], ef[0][i]);
      chk($sformatf("%s_Cb%0d", nm, i), obs[1][i], ef[1][i]);
      chk($sformatf("%s_Cr%0d", nm, i), obs[2][i], ef[2][i]);
    end
    chk({nm, "_valid_low_done"}, int'(dct_valid), 0);
    chk({nm, "_hold_Y"}, int'(dct_Y), ef[0][63]);
    chk({nm, "_hold_Cr"}, int'(dct_Cr), ef[2][63]);
    chk({nm, "_hold_index"}, int'(dct_index), 63);
  endtask

  initial begin
    int seen;
    build_table();
    chk("table_dc", tab[0][5], 91);
    chk("table_k1", tab[1][0], 126);

    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom); pixel_valid = 1'($urandom);
      R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_Y", int'(dct_Y), 0);
    chk("rst_Cb", int'(dct_Cb), 0);
    chk("rst_Cr", int'(dct_Cr), 0);
    chk("rst_valid", int'(dct_valid), 0);
    chk("rst_index", int'(dct_index), 0);
    chk("rst_done", int'(done), 0);
    start = 1'b0;
    rst_n = 1'b1;

    repeat (5) begin
      pixel_valid = 1'b1;
      R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
      @(negedge clk);
    end
    pixel_valid = 1'b0;

    set_ramp();
    run_block("ramp", 1'b0, 1'b1);
    chk("ramp_cr_dc", obs[2][0], -9);
    for (int i = 1; i < 64; i++)
      chk($sformatf("ramp_cr_ac%0d", i), obs[2][i], 0);
    for (int i = 0; i < 64; i++)
      chk($sformatf("ramp_cb_zero%0d", i), obs[1][i], 0);

    set_flat(128);
    run_block("flat", 1'b0, 1'b0);
    for (int i = 0; i < 64; i++)
      chk($sformatf("flat_y_zero%0d", i), obs[0][i], 0);

    set_ramp();
    run_block("gap", 1'b1, 1'b0);

    set_flat(255);
    run_block("white", 1'b0, 1'b0);
    chk("white_cb_dc", obs[1][0], 0);

    set_flat(0);
    run_block("black", 1'b0, 1'b0);
    chk("black_cr_dc", obs[2][0], 0);

    set_rand();
    run_block("rand0", 1'b0, 1'b0);
    set_rand();
    run_block("rand1", 1'b1, 1'b1);

    set_rand();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed(1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_done", int'(done), 0);
    chk("abort_valid", int'(dct_valid), 0);
    chk("abort_index", int'(dct_index), 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (1200) begin
      @(negedge clk);
      if (done || dct_valid) seen++;
    end
    chk("abort_stays_idle", seen, 0);

    set_rand();
    run_block("after_abort", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
